// File: rtl/obs_sink_cmp.sv
// Lockstep observation comparator. Left and right observation streams each go
// into their own FIFO, and the block compares them in pairs to detect divergence.
module obs_sink_cmp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             l_cond,
    input  logic [WIDTH-1:0] l_arg0,
    input  logic             r_cond,
    input  logic [WIDTH-1:0] r_arg0,
    input  logic             finish,
    output logic             done,
    output logic             leak,
    output logic             overflow,
    output logic [15:0]      match_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        FAIL
    } state_t;

    state_t                state_reg;

    logic [1:0]            push_req;
    logic [1:0]            push_ok;
    logic [1:0]            push_drop;
    logic [1:0]            empty;
    logic [1:0]            full;
    logic [1:0][WIDTH-1:0] push_data;
    logic [1:0][WIDTH-1:0] head_data;
    logic                  active;
    logic                  pop;
    logic                  any_drop;

    logic [WIDTH-1:0]      cmp_l_reg;
    logic [WIDTH-1:0]      cmp_r_reg;
    logic                  cmp_valid_reg;
    logic                  cmp_match;
    logic                  cmp_mismatch;

    logic                  done_reg;
    logic                  leak_reg;
    logic                  overflow_reg;
    logic [15:0]           match_count_reg;

    assign active       = (state_reg == RUN) || (state_reg == DRAIN);
    assign pop          = active && (empty == 2'b00);
    assign push_req     = {r_cond, l_cond} & {2{state_reg == RUN}};
    assign push_data[0] = l_arg0;
    assign push_data[1] = r_arg0;
    assign any_drop     = |push_drop;

    // Index 0 is the left copy, index 1 the right copy.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr_reg;
        logic [PW-1:0]    rd_ptr_reg;

        assign empty[gi]     = (wr_ptr_reg == rd_ptr_reg);
        assign full[gi]      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                               (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
        // A full side still accepts a push when the pair pop frees a slot.
        assign push_ok[gi]   = push_req[gi] && (!full[gi] || pop);
        assign push_drop[gi] = push_req[gi] && full[gi] && !pop;
        assign head_data[gi] = mem[rd_ptr_reg[AW-1:0]];

        always_ff @(posedge clock) begin
            if (push_ok[gi]) begin
                mem[wr_ptr_reg[AW-1:0]] <= push_data[gi];
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    assign cmp_match    = cmp_valid_reg && (cmp_l_reg == cmp_r_reg);
    assign cmp_mismatch = cmp_valid_reg && (cmp_l_reg != cmp_r_reg);

    // Popped heads are registered first and judged one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RUN;
            cmp_valid_reg   <= 1'b0;
            cmp_l_reg       <= '0;
            cmp_r_reg       <= '0;
            done_reg        <= 1'b0;
            leak_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
            match_count_reg <= '0;
        end else begin
            cmp_valid_reg <= pop;
            if (pop) begin
                cmp_l_reg <= head_data[0];
                cmp_r_reg <= head_data[1];
            end
            if (active && cmp_match && (match_count_reg != 16'hFFFF)) begin
                match_count_reg <= match_count_reg + 16'd1;
            end
            if (any_drop) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                RUN: begin
                    // Divergence outranks a simultaneous finish.
                    if (cmp_mismatch || any_drop) begin
                        state_reg <= FAIL;
                        leak_reg  <= 1'b1;
                    end else if (finish) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cmp_mismatch) begin
                        state_reg <= FAIL;
                        leak_reg  <= 1'b1;
                    end else if (empty == 2'b11) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (empty != 2'b00) begin
                        state_reg <= FAIL;
                        leak_reg  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done        = done_reg;
    assign leak        = leak_reg;
    assign overflow    = overflow_reg;
    assign match_count = match_count_reg;

endmodule
